// File: rtl/stream_demux_1_4.sv
// 1-to-4 valid/ready stream demultiplexer. The route is chosen on a packet's first beat and held until its last beat.
// Each channel has a one-entry holding register, so a stalled channel does not block the other channels.

module stream_demux_1_4_chan #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] ld_data,
    input  logic         ld_last,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         last
);
    // A load takes priority over a drain, so a drain and a load in the same cycle leave no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (ld) begin
            valid <= 1'b1;
            data  <= ld_data;
            last  <= ld_last;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end
endmodule

module stream_demux_1_4 #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic           in_last,
    input  logic [1:0]     in_sel,
    output logic [3:0]     out_valid,
    input  logic [3:0]     out_ready,
    output logic [4*W-1:0] out_data,
    output logic [3:0]     out_last,
    output logic           busy,
    output logic [1:0]     cur_sel
);
    localparam int NUM_CH = 4;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state, state_nxt;
    logic [1:0] sel_nxt;
    logic [1:0] route;
    logic       accept;

    assign route    = (state == IDLE) ? in_sel : cur_sel;
    assign in_ready = ~out_valid[route] | out_ready[route];
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cur_sel <= 2'd0;
        end else begin
            state   <= state_nxt;
            cur_sel <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = cur_sel;
        if (accept) begin
            case (state)
                IDLE: if (!in_last) begin
                    state_nxt = BUSY;
                    sel_nxt   = in_sel;
                end
                BUSY: if (in_last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == BUSY);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        stream_demux_1_4_chan #(.W(W)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .ld      (accept && (route == i)),
            .ld_data (in_data),
            .ld_last (in_last),
            .ready   (out_ready[i]),
            .valid   (out_valid[i]),
            .data    (out_data[i*W +: W]),
            .last    (out_last[i])
        );
    end
endmodule

// File: tb/tb_stream_demux_1_4.sv
// Scoreboard bench for stream_demux_1_4: accepted beats are queued per channel and a negedge monitor checks each output handshake.
// Directed cases check exact values, and a random soak checks for lost, duplicated, reordered or misrouted beats.

module tb_stream_demux_1_4;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_last;
    logic        busy;
    logic [1:0]  cur_sel;

    stream_demux_1_4 #(.W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .cur_sel(cur_sel)
    );

    always #5 clk = ~clk;

    int         nchk = 0;
    int         npass = 0;
    logic [8:0] exq [4][$];
    logic       m_busy = 1'b0;
    logic [1:0] m_sel = 2'd0;
    logic       soak = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // The bench's own packet-lock model decides which queue receives each accepted beat.
    task automatic beat(input logic [1:0] sel, input logic [7:0] d, input logic last, output int waits);
        logic [1:0] r;
        bit done = 0;
        in_valid = 1'b1; in_sel = sel; in_data = d; in_last = last;
        waits = 0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                r = m_busy ? m_sel : sel;
                exq[r].push_back({last, d});
                if (!m_busy && !last) begin m_busy = 1'b1; m_sel = r; end
                else if (m_busy && last) m_busy = 1'b0;
                done = 1;
            end else if (waits > 200) begin
                chk("beat_timeout", 32'(waits), 32'd0);
                done = 1;
            end
            waits++;
            @(posedge clk); #1;
        end
        waits--;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic chan(input string name, input int i, input logic [7:0] d);
        chk({name, "_valid"}, 32'(out_valid[i]), 32'd1);
        chk({name, "_data"}, 32'(out_data[i*8 +: 8]), 32'(d));
    endtask

    // Monitor: pops on every output handshake, and checks that a stalled beat is held unchanged.
    logic [3:0] pv = '0, pr = '0, pl = '0;
    logic [7:0] pd [4];
    always @(negedge clk) begin
        if (rst) begin
            pv = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pv[i] && !pr[i])
                    chk($sformatf("hold_ch%0d", i), {out_valid[i], out_last[i], out_data[i*8 +: 8]},
                        {1'b1, pl[i], pd[i]});
                if (out_valid[i] && out_ready[i]) begin
                    if (exq[i].size() == 0) chk($sformatf("extra_beat_ch%0d", i), 32'd1, 32'd0);
                    else chk($sformatf("beat_ch%0d", i), 32'({out_last[i], out_data[i*8 +: 8]}),
                             32'(exq[i].pop_front()));
                end
                pd[i] = out_data[i*8 +: 8];
            end
            pv = out_valid; pr = out_ready; pl = out_last;
        end
    end

    always @(posedge clk) begin
        #1;
        if (soak) out_ready = 4'($urandom);
    end

    initial begin
        int w;
        rst = 1'b1; in_valid = 0; in_data = 0; in_last = 0; in_sel = 0; out_ready = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cur_sel", 32'(cur_sel), 32'd0);
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Single-beat packets, one per channel, on consecutive cycles.
        for (int k = 0; k < 4; k++) begin
            beat(2'(k), 8'h10 + 8'(k), 1'b1, w);
            chk("single_wait", 32'(w), 32'd0);
            chan($sformatf("single_ch%0d", k), k, 8'h10 + 8'(k));
            chk("single_busy", 32'(busy), 32'd0);
        end
        idle();

        // Locked route: a multi-beat packet ignores in_sel after its first beat.
        beat(2'd2, 8'hA0, 1'b0, w);
        chk("lock_busy0", 32'(busy), 32'd1);
        chk("lock_sel0", 32'(cur_sel), 32'd2);
        chan("lock_b0", 2, 8'hA0);
        beat(2'd1, 8'hA1, 1'b0, w);
        chan("lock_b1", 2, 8'hA1);
        beat(2'd1, 8'hA2, 1'b1, w);
        chan("lock_b2", 2, 8'hA2);
        chk("lock_busy2", 32'(busy), 32'd0);
        chk("lock_sel2", 32'(cur_sel), 32'd2);
        idle();
        @(posedge clk); #1;

        // Backpressure on channel 1: the second beat waits, then replaces the first with no gap.
        out_ready = 4'b1101;
        beat(2'd1, 8'h55, 1'b1, w);
        chan("bp_first", 1, 8'h55);
        in_sel = 2'd1; in_data = 8'h66; in_last = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chan("bp_still", 1, 8'h55);
        out_ready = 4'hF;
        beat(2'd1, 8'h66, 1'b1, w);
        chk("bp_wait", 32'(w), 32'd0);
        chan("bp_second", 1, 8'h66);
        idle();
        @(posedge clk); #1;

        // Independent channels: stalled channel 0 does not block channel 3.
        out_ready = 4'b1110;
        beat(2'd0, 8'h01, 1'b1, w);
        beat(2'd3, 8'h77, 1'b1, w);
        chk("indep_wait", 32'(w), 32'd0);
        chan("indep_ch3", 3, 8'h77);
        chan("indep_ch0", 0, 8'h01);
        idle();
        out_ready = 4'hF;
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset between clock edges while a packet is open.
        beat(2'd2, 8'hC0, 1'b0, w);
        beat(2'd2, 8'hC1, 1'b0, w);
        idle();
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) exq[i].delete();
        m_busy = 1'b0; m_sel = 2'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        beat(2'd0, 8'hD0, 1'b1, w);
        chan("arst_after", 0, 8'hD0);
        chk("arst_after_busy", 32'(busy), 32'd0);
        idle();

        // Random soak
        soak = 1'b1;
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                idle();
                @(posedge clk); #1;
            end
            beat(2'($urandom), 8'($urandom), 1'($urandom_range(0, 2) == 0), w);
        end
        idle();
        soak = 1'b0;
        out_ready = 4'hF;
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("drain_ch%0d", i), 32'(exq[i].size()), 32'd0);
        chk("end_out_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
